uart_tx_queue: RTL and testbench

Byte queue and launch controller that sits directly upstream of the UART top (TX side). It accepts bytes from a producer over a valid/ready handshake, buffers them in a FIFO, and issues them one at a time to the UART transmitter via the `tx_start`/`tx_data`/`tx_busy` interface. This removes the need for software or bench code to poll `tx_busy` per byte.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_tx_queue.sv | 128 ++++++++++++
 tb/tb_uart_tx_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART TX launch queue.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } txq_state_t;

  localparam int DEFAULT_DEPTH       = 16;
  localparam int DEFAULT_ACK_TIMEOUT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with occupancy count and synchronous flush.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// push must already be qualified by the caller (valid && ready).
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  byte_t                  wr_data,
  input  logic                   pop,
  input  logic                   flush,
  output byte_t                  rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  byte_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Storage write; a flush cycle never stores the offered byte.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; flush overrides any push/pop that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of the UART transmitter: buffers producer bytes and
// launches them one at a time using the tx_start / tx_busy handshake.
//
// state     | meaning
// IDLE      | waiting for a queued byte and an idle UART
// WAIT_BUSY | byte launched, waiting for tx_busy to rise (timeout guarded)
// WAIT_DONE | UART transmitting, waiting for tx_busy to fall
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   ack_err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  txq_state_t    state;
  txq_state_t    state_next;
  logic          push;
  logic          launch;
  logic          timeout_hit;
  logic          set_err;
  logic [TW-1:0] timer;
  byte_t         rd_data;

  // No pass-through when full: a same-cycle pop does not open a slot.
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (in_data),
    .pop     (launch),
    .flush   (flush),
    .rd_data (rd_data),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  assign timeout_hit = (timer == TW'(ACK_TIMEOUT - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)          state_next = WAIT_DONE;
        else if (timeout_hit) state_next = IDLE;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-state control strobes: launch pops the FIFO, set_err flags a dropped byte.
  always_comb begin
    launch  = 1'b0;
    set_err = 1'b0;
    case (state)
      IDLE:      launch  = !empty && !tx_busy;
      WAIT_BUSY: set_err = !tx_busy && timeout_hit;
      default: begin
        launch  = 1'b0;
        set_err = 1'b0;
      end
    endcase
  end

  // Launch registers: tx_start pulses for one cycle, tx_data holds until the next launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= launch;
      if (launch) tx_data <= rd_data;
    end
  end

  // Busy-acknowledge timer and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      ack_err <= 1'b0;
    end else begin
      if (launch) begin
        timer <= '0;
      end else if (state == WAIT_BUSY && !tx_busy) begin
        timer <= timer + 1'b1;
      end
      if (set_err) ack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a small behavioural UART TX model.
module tb_uart_tx_queue;

  localparam int BUSY_CYC = 5;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       flush    = 1'b0;
  logic       in_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       ack_err;

  // UART model state (deliberately not reset: it finishes on its own)
  logic       hold_busy = 1'b0;
  logic       uart_en   = 1'b1;
  logic       m_busy    = 1'b0;
  int         m_cnt     = 0;
  logic [7:0] m_byte    = 8'h00;
  logic [7:0] rx_buf [0:255];
  int         rx_n      = 0;
  int         n_fall    = 0;
  int         n_start   = 0;
  logic       prev_start = 1'b0;
  int         n_dbl     = 0;

  int n_vec = 0;
  int n_err = 0;

  assign tx_busy = m_busy | hold_busy;

  uart_tx_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .ack_err  (ack_err)
  );

  always #10 clk = ~clk;

  // UART TX model: busy for BUSY_CYC cycles after a start, then "receives" the byte
  always @(posedge clk) begin
    if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy       <= 1'b0;
        rx_buf[rx_n] <= m_byte;
        rx_n         <= rx_n + 1;
        n_fall       <= n_fall + 1;
      end
      m_cnt <= m_cnt - 1;
    end else if (tx_start && uart_en) begin
      m_busy <= 1'b1;
      m_cnt  <= BUSY_CYC;
      m_byte <= tx_data;
    end
  end

  // Launch monitor
  always @(negedge clk) begin
    if (tx_start) n_start <= n_start + 1;
    if (tx_start && prev_start) n_dbl <= n_dbl + 1;
    prev_start <= tx_start;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      in_data  = first + 8'(i);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (rx_n < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, rx_n, target);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base;
    int s0;
    int f0;

    // reset
    #1 rst_n = 1'b0;
    #2;
    check_val("rst_tx_start", tx_start, 0);
    check_val("rst_tx_data", tx_data, 0);
    check_val("rst_count", count, 0);
    check_val("rst_empty", empty, 1);
    check_val("rst_full", full, 0);
    check_val("rst_ack_err", ack_err, 0);
    check_val("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single byte latency
    base = rx_n;
    in_data = 8'hA5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("single_cnt", count, 1);
    check_val("single_early", tx_start, 0);
    @(negedge clk);
    check_val("single_start", tx_start, 1);
    check_val("single_data", tx_data, 8'hA5);
    check_val("single_cnt0", count, 0);
    @(negedge clk);
    check_val("single_pulse", tx_start, 0);
    wait_rx("single_drain", base + 1, 100);
    check_val("single_rx", rx_buf[base], 8'hA5);

    // burst to full, 17th held
    base = rx_n; s0 = n_start; f0 = n_fall;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      @(negedge clk);
    end
    in_data = 8'h10;
    check_val("burst_full", full, 1);
    check_val("burst_ready", in_ready, 0);
    check_val("burst_cnt", count, 16);
    repeat (2) @(negedge clk);
    check_val("burst_hold_cnt", count, 16);
    hold_busy = 1'b0;
    @(negedge clk);
    check_val("burst_pop_start", tx_start, 1);
    check_val("burst_pop_data", tx_data, 8'h00);
    check_val("burst_pop_cnt", count, 15);
    check_val("burst_pop_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("burst_17_cnt", count, 16);
    wait_rx("burst_drain", base + 17, 600);
    for (int i = 0; i < 17; i++) check_val("burst_order", rx_buf[base + i], i);
    check_val("burst_starts", n_start - s0, 17);
    check_val("burst_falls", n_fall - f0, 17);

    // push while popping at count 5
    base = rx_n;
    hold_busy = 1'b1;
    push_bytes(8'h20, 5);
    check_val("pp_cnt_pre", count, 5);
    in_data = 8'h25; in_valid = 1'b1; hold_busy = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("pp_cnt", count, 5);
    check_val("pp_start", tx_start, 1);
    check_val("pp_data", tx_data, 8'h20);
    wait_rx("pp_drain", base + 6, 300);
    for (int i = 0; i < 6; i++) check_val("pp_order", rx_buf[base + i], 8'h20 + i);

    // flush with one in flight and four queued
    base = rx_n; s0 = n_start;
    hold_busy = 1'b1;
    push_bytes(8'h30, 5);
    hold_busy = 1'b0;
    @(negedge clk);
    check_val("fl_start", tx_start, 1);
    check_val("fl_cnt4", count, 4);
    repeat (2) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    #1;
    check_val("fl_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check_val("fl_cnt", count, 0);
    check_val("fl_empty", empty, 1);
    wait_rx("fl_drain", base + 1, 100);
    repeat (20) @(negedge clk);
    check_val("fl_rx_n", rx_n, base + 1);
    check_val("fl_rx", rx_buf[base], 8'h30);
    check_val("fl_starts", n_start - s0, 1);
    check_val("fl_tx_data", tx_data, 8'h30);

    // ack timeout with tx_busy stuck low
    uart_en = 1'b0;
    hold_busy = 1'b1;
    push_bytes(8'h41, 2);
    hold_busy = 1'b0;
    @(negedge clk);
    check_val("to_start", tx_start, 1);
    check_val("to_err0", ack_err, 0);
    repeat (3) @(negedge clk);
    check_val("to_err_l3", ack_err, 0);
    @(negedge clk);
    check_val("to_err_l4", ack_err, 1);
    @(negedge clk);
    check_val("to_next_start", tx_start, 1);
    check_val("to_next_data", tx_data, 8'h42);
    repeat (6) @(negedge clk);
    uart_en = 1'b1;
    check_val("to_sticky", ack_err, 1);
    check_val("to_empty", empty, 1);

    // async reset during WAIT_DONE with three queued
    hold_busy = 1'b1;
    push_bytes(8'h50, 4);
    hold_busy = 1'b0;
    @(negedge clk);
    check_val("rs_start", tx_start, 1);
    check_val("rs_cnt3", count, 3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rs_tx_start", tx_start, 0);
    check_val("rs_tx_data", tx_data, 0);
    check_val("rs_count", count, 0);
    check_val("rs_empty", empty, 1);
    check_val("rs_ack_err", ack_err, 0);
    check_val("rs_in_ready", in_ready, 1);
    s0 = n_start;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("rs_no_start", n_start, s0);
    base = rx_n;
    in_data = 8'h60; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("rs_new_early", tx_start, 0);
    @(negedge clk);
    check_val("rs_new_start", tx_start, 1);
    check_val("rs_new_data", tx_data, 8'h60);
    wait_rx("rs_drain", base + 1, 100);
    check_val("rs_new_rx", rx_buf[base], 8'h60);

    check_val("single_cycle_pulses", n_dbl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
